// File: rtl/riscv_pkg.sv
// Shared RISC-V core types.
// Hazard sequencer state encoding and register constants.
package riscv_pkg;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MC_START = 2'd1,
      HZ_MC_WAIT  = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use, multi-cycle ops,
// data-memory wait states and taken-branch flushes.
module hazard_controller
   import riscv_pkg::*;
#(
   parameter int STALL_CNT_W = 32,
   parameter int MC_TIMEOUT  = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4:0]             if_id_rs1,
   input  logic [4:0]             if_id_rs2,
   input  logic                   if_id_use_rs1,
   input  logic                   if_id_use_rs2,
   input  logic                   if_id_valid,
   input  logic [4:0]             id_ex_rd,
   input  logic                   id_ex_mem_read,
   input  logic                   id_ex_is_mc,
   input  logic                   id_ex_valid,
   input  logic                   branch_taken,
   input  logic                   mc_done,
   input  logic                   dmem_req,
   input  logic                   dmem_ready,
   output logic                   stall_if,
   output logic                   stall_id,
   output logic                   stall_ex,
   output logic                   stall_mem,
   output logic                   flush_if_id,
   output logic                   flush_id_ex,
   output logic                   mc_start,
   output logic                   mc_timeout_err,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output hz_state_e              state_o
);

   localparam int TO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

   hz_state_e       state_q;
   hz_state_e       state_d;
   logic            done_q;
   logic            done_d;
   logic            err_q;
   logic            err_d;
   logic            mem_wait;
   logic            load_use;
   logic            rs1_hit;
   logic            rs2_hit;
   logic            to_inc;
   logic            to_clr;
   logic [TO_W-1:0] to_cnt;

   assign mem_wait = dmem_req & ~dmem_ready;

   assign rs1_hit  = if_id_use_rs1 & (if_id_rs1 == id_ex_rd);
   assign rs2_hit  = if_id_use_rs2 & (if_id_rs2 == id_ex_rd);
   assign load_use = id_ex_valid & id_ex_mem_read
                   & (id_ex_rd != REG_ZERO)
                   & if_id_valid & (rs1_hit | rs2_hit);

   always_comb begin
      state_d     = state_q;
      done_d      = done_q;
      err_d       = err_q;
      to_inc      = 1'b0;
      to_clr      = 1'b0;
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      stall_mem   = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      mc_start    = 1'b0;

      // Outputs are forced quiet while reset is held
      if (!rst_n) begin
         state_d = HZ_RUN;
      end else if (mem_wait) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         stall_ex  = 1'b1;
         stall_mem = 1'b1;
         if ((state_q == HZ_MC_WAIT) && mc_done) begin
            done_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            HZ_RUN: begin
               if (branch_taken && id_ex_valid) begin
                  flush_if_id = 1'b1;
                  flush_id_ex = 1'b1;
               end else if (id_ex_valid && id_ex_is_mc) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  state_d  = HZ_MC_START;
               end else if (load_use) begin
                  stall_if    = 1'b1;
                  stall_id    = 1'b1;
                  flush_id_ex = 1'b1;
               end
            end
            HZ_MC_START: begin
               mc_start = 1'b1;
               stall_if = 1'b1;
               stall_id = 1'b1;
               stall_ex = 1'b1;
               to_clr   = 1'b1;
               state_d  = HZ_MC_WAIT;
            end
            HZ_MC_WAIT: begin
               stall_if = 1'b1;
               stall_id = 1'b1;
               stall_ex = 1'b1;
               to_inc   = 1'b1;
               if (mc_done || done_q) begin
                  done_d  = 1'b0;
                  state_d = HZ_RUN;
               end else if (to_cnt == TO_LAST) begin
                  err_d   = 1'b1;
                  state_d = HZ_RUN;
               end
            end
            default: begin
               state_d = HZ_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HZ_RUN;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   sat_counter #(
      .W (TO_W)
   ) u_to_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (to_inc),
      .clr   (to_clr),
      .q     (to_cnt)
   );

   sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_if),
      .clr   (1'b0),
      .q     (stall_cycles)
   );

   assign mc_timeout_err = err_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and random checks of hazard_controller against
// a cycle-level behavioural model.
module tb_hazard_controller;
   import riscv_pkg::*;

   localparam int CW  = 8;
   localparam int MCT = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
   logic if_id_use_rs1, if_id_use_rs2, if_id_valid;
   logic id_ex_mem_read, id_ex_is_mc, id_ex_valid;
   logic branch_taken, mc_done, dmem_req, dmem_ready;
   logic stall_if, stall_id, stall_ex, stall_mem;
   logic flush_if_id, flush_id_ex, mc_start, mc_timeout_err;
   logic [CW-1:0] stall_cycles;
   hz_state_e state_o;

   int nvec = 0;
   int nerr = 0;

   int m_mode, m_wait, m_cnt;
   bit m_done, m_err, t_mw;
   bit e_sif, e_sid, e_sex, e_smem, e_fif, e_fex, e_mcs;

   always #5 clk = ~clk;

   hazard_controller #(
      .STALL_CNT_W (CW),
      .MC_TIMEOUT  (MCT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2),
      .if_id_use_rs1  (if_id_use_rs1),
      .if_id_use_rs2  (if_id_use_rs2),
      .if_id_valid    (if_id_valid),
      .id_ex_rd       (id_ex_rd),
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_is_mc    (id_ex_is_mc),
      .id_ex_valid    (id_ex_valid),
      .branch_taken   (branch_taken),
      .mc_done        (mc_done),
      .dmem_req       (dmem_req),
      .dmem_ready     (dmem_ready),
      .stall_if       (stall_if),
      .stall_id       (stall_id),
      .stall_ex       (stall_ex),
      .stall_mem      (stall_mem),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .mc_start       (mc_start),
      .mc_timeout_err (mc_timeout_err),
      .stall_cycles   (stall_cycles),
      .state_o        (state_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rd = 0;
      if_id_use_rs1 = 0; if_id_use_rs2 = 0; if_id_valid = 0;
      id_ex_mem_read = 0; id_ex_is_mc = 0; id_ex_valid = 0;
      branch_taken = 0; mc_done = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   task automatic model_reset();
      m_mode = 0; m_wait = 0; m_cnt = 0; m_done = 0; m_err = 0;
   endtask

   task automatic eval();
      bit lu;
      #1;
      t_mw = dmem_req && !dmem_ready;
      lu = id_ex_valid && id_ex_mem_read && id_ex_rd != 0 && if_id_valid &&
           ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) ||
            (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
      {e_sif, e_sid, e_sex, e_smem, e_fif, e_fex, e_mcs} = '0;
      if (!rst_n) begin
      end else if (t_mw) begin
         {e_sif, e_sid, e_sex, e_smem} = 4'hF;
      end else if (m_mode == 0) begin
         if (branch_taken && id_ex_valid) {e_fif, e_fex} = 2'b11;
         else if (id_ex_valid && id_ex_is_mc) {e_sif, e_sid} = 2'b11;
         else if (lu) {e_sif, e_sid, e_fex} = 3'b111;
      end else begin
         {e_sif, e_sid, e_sex} = 3'b111;
         e_mcs = (m_mode == 1);
      end
      chk("ctl", {stall_if, stall_id, stall_ex, stall_mem, flush_if_id,
                  flush_id_ex, mc_start, mc_timeout_err},
          {e_sif, e_sid, e_sex, e_smem, e_fif, e_fex, e_mcs, m_err});
      chk("stall_cycles", 32'(stall_cycles), m_cnt);
      chk("state", 32'(int'(state_o)), m_mode);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         if (e_sif && m_cnt < 255) m_cnt++;
         if (t_mw) begin
            if (m_mode == 2 && mc_done) m_done = 1;
         end else begin
            case (m_mode)
               0: if (!(branch_taken && id_ex_valid) &&
                      id_ex_valid && id_ex_is_mc) m_mode = 1;
               1: begin m_mode = 2; m_wait = 0; end
               default: begin
                  if (mc_done || m_done) begin
                     m_mode = 0; m_done = 0;
                  end else if (m_wait == MCT - 1) begin
                     m_err = 1; m_mode = 0;
                  end else begin
                     m_wait++;
                  end
               end
            endcase
         end
      end
      @(negedge clk);
   endtask

   task automatic step();
      eval();
      tick();
   endtask

   task automatic mc_op();
      id_ex_valid = 1; id_ex_is_mc = 1;
   endtask

   initial begin
      int mcs_seen;
      int base;
      idle();
      model_reset();
      // reset
      repeat (2) @(negedge clk);
      eval();
      chk("rst_state", 32'(int'(state_o)), 0);
      chk("rst_cnt", 32'(stall_cycles), 0);
      rst_n = 1;
      step();

      // 1: load-use
      id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 5;
      if_id_valid = 1; if_id_use_rs1 = 1; if_id_use_rs2 = 1;
      if_id_rs1 = 5; if_id_rs2 = 1;
      eval();
      chk("lu_stall", {stall_if, stall_id, flush_id_ex}, 3'b111);
      tick();
      idle(); if_id_valid = 1; if_id_use_rs1 = 1; if_id_rs1 = 5;
      eval();
      chk("lu_after", {stall_if, stall_id, flush_id_ex}, 3'b000);
      chk("lu_cnt", 32'(stall_cycles), 1);
      tick();

      // 2: zero register and unused rs2
      idle();
      id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 0;
      if_id_valid = 1; if_id_use_rs1 = 1; if_id_rs1 = 0;
      eval();
      chk("x0_nostall", 32'(stall_if), 0);
      tick();
      id_ex_rd = 7; if_id_use_rs1 = 0; if_id_use_rs2 = 0; if_id_rs2 = 7;
      eval();
      chk("rs2_unused", 32'(stall_if), 0);
      tick();

      // 3: MC op, done 4 cycles after start
      idle(); mc_op();
      base = m_cnt;
      mcs_seen = 0;
      step();
      for (int i = 0; i < 5; i++) begin
         mc_done = (i == 4);
         eval();
         mcs_seen += int'(mc_start);
         chk("mc_hold", {stall_if, stall_id, stall_ex}, 3'b111);
         tick();
      end
      idle();
      eval();
      chk("mc_run", 32'(int'(state_o)), 0);
      chk("mc_pulses", mcs_seen, 1);
      chk("mc_cnt", 32'(stall_cycles), base + 6);
      tick();

      // 4: done latched under mem_wait
      mc_op();
      step();
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         dmem_req = 1; dmem_ready = 0; mc_done = (i == 1);
         eval();
         chk("mw_all", {stall_if, stall_id, stall_ex, stall_mem}, 4'hF);
         tick();
      end
      dmem_req = 0; mc_done = 0;
      step();
      idle();
      eval();
      chk("mw_done_run", 32'(int'(state_o)), 0);
      tick();

      // 5: branch beats load-use; deferred under mem_wait
      id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 9; branch_taken = 1;
      if_id_valid = 1; if_id_use_rs1 = 1; if_id_rs1 = 9;
      eval();
      chk("br_flush", {flush_if_id, flush_id_ex, stall_if}, 3'b110);
      tick();
      for (int i = 0; i < 3; i++) begin
         dmem_req = 1; dmem_ready = (i == 2);
         eval();
         chk("br_mw", 32'(flush_if_id), (i == 2) ? 1 : 0);
         tick();
      end

      // 6: timeout, sticky error, async reset mid-wait
      idle(); mc_op();
      step();
      step();
      for (int i = 0; i < MCT; i++) step();
      idle();
      eval();
      chk("to_err", 32'(mc_timeout_err), 1);
      chk("to_run", 32'(int'(state_o)), 0);
      tick();
      repeat (3) step();
      mc_op();
      repeat (4) step();
      #2 rst_n = 0;
      #1;
      chk("arst_state", 32'(int'(state_o)), 0);
      chk("arst_err", 32'(mc_timeout_err), 0);
      chk("arst_cnt", 32'(stall_cycles), 0);
      chk("arst_out", {stall_if, stall_id, stall_ex, mc_start}, 4'h0);
      model_reset();
      @(negedge clk);
      idle();
      rst_n = 1;
      step();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if_id_rs1 = 5'($urandom_range(0, 3));
         if_id_rs2 = 5'($urandom_range(0, 3));
         id_ex_rd = 5'($urandom_range(0, 3));
         if_id_use_rs1 = 1'($urandom);
         if_id_use_rs2 = 1'($urandom);
         if_id_valid = 1'($urandom_range(0, 3) != 0);
         id_ex_valid = 1'($urandom_range(0, 3) != 0);
         id_ex_mem_read = 1'($urandom);
         id_ex_is_mc = ($urandom_range(0, 7) == 0);
         branch_taken = ($urandom_range(0, 7) == 0);
         dmem_req = ($urandom_range(0, 2) == 0);
         dmem_ready = 1'($urandom);
         mc_done = (m_mode != 1) && ($urandom_range(0, 5) == 0);
         step();
      end

      // saturation
      idle();
      dmem_req = 1;
      for (int n = 0; n < 260; n++) step();
      eval();
      chk("sat_cnt", 32'(stall_cycles), 255);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
